// File: rtl/sound_arbiter_pkg.sv
// Shared definitions for the sound arbiter: effect IDs, priority order,
// effect table and FSM state encoding.
package sound_arbiter_pkg;

  localparam int INC_W = 11;  // phase increment width
  localparam int DUR_W = 8;   // duration / gap counter width
  localparam int REQ_W = 3;   // number of request lines

  // Effect IDs. The numeric value doubles as the priority: a larger ID wins.
  localparam logic [1:0] SFX_NONE = 2'd0;
  localparam logic [1:0] SFX_DROP = 2'd1;
  localparam logic [1:0] SFX_LINE = 2'd2;
  localparam logic [1:0] SFX_OVER = 2'd3;

  // Effect table: increment and duration (in ticks) for step 0 and step 1.
  localparam logic [INC_W-1:0] DROP_INC0 = 11'h0A0;
  localparam logic [DUR_W-1:0] DROP_DUR0 = 8'd3;
  localparam logic [INC_W-1:0] DROP_INC1 = 11'h050;
  localparam logic [DUR_W-1:0] DROP_DUR1 = 8'd3;
  localparam logic [INC_W-1:0] LINE_INC0 = 11'h2A0;
  localparam logic [DUR_W-1:0] LINE_DUR0 = 8'd60;
  localparam logic [INC_W-1:0] LINE_INC1 = 11'h37F;
  localparam logic [DUR_W-1:0] LINE_DUR1 = 8'd90;
  localparam logic [INC_W-1:0] OVER_INC0 = 11'h1F0;
  localparam logic [DUR_W-1:0] OVER_DUR0 = 8'd150;
  localparam logic [INC_W-1:0] OVER_INC1 = 11'h0F8;
  localparam logic [DUR_W-1:0] OVER_DUR1 = 8'd250;

  typedef enum logic [1:0] {
    ST_MELODY = 2'd0,
    ST_SFX0   = 2'd1,
    ST_SFX1   = 2'd2,
    ST_GAP    = 2'd3
  } sa_state_e;

  // Highest-priority pending effect: game over > line clear > drop.
  function automatic logic [1:0] top_pending(input logic [REQ_W-1:0] p);
    if (p[2])      return SFX_OVER;
    else if (p[1]) return SFX_LINE;
    else if (p[0]) return SFX_DROP;
    else           return SFX_NONE;
  endfunction

  // Pending-register bit belonging to an effect ID.
  function automatic logic [REQ_W-1:0] id_mask(input logic [1:0] id);
    case (id)
      SFX_DROP: return 3'b001;
      SFX_LINE: return 3'b010;
      SFX_OVER: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic [INC_W-1:0] sfx_inc(input logic [1:0] id, input logic step);
    case ({id, step})
      {SFX_DROP, 1'b0}: return DROP_INC0;
      {SFX_DROP, 1'b1}: return DROP_INC1;
      {SFX_LINE, 1'b0}: return LINE_INC0;
      {SFX_LINE, 1'b1}: return LINE_INC1;
      {SFX_OVER, 1'b0}: return OVER_INC0;
      {SFX_OVER, 1'b1}: return OVER_INC1;
      default:          return '0;
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] sfx_dur(input logic [1:0] id, input logic step);
    case ({id, step})
      {SFX_DROP, 1'b0}: return DROP_DUR0;
      {SFX_DROP, 1'b1}: return DROP_DUR1;
      {SFX_LINE, 1'b0}: return LINE_DUR0;
      {SFX_LINE, 1'b1}: return LINE_DUR1;
      {SFX_OVER, 1'b0}: return OVER_DUR0;
      {SFX_OVER, 1'b1}: return OVER_DUR1;
      default:          return '0;
    endcase
  endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// Signal bundle between the game logic / melody sequencer (master) and the
// sound arbiter (slave).
// Protocol: there is no valid/ready handshake. sfx_req bits are one-cycle
// event pulses that the arbiter always accepts while en is high; melody_inc
// is a level sampled every clock; all outputs are registered levels.
interface sound_arbiter_if;
  import sound_arbiter_pkg::*;

  logic             en;
  logic [INC_W-1:0] melody_inc;
  logic [REQ_W-1:0] sfx_req;
  logic [INC_W-1:0] tone_inc;
  logic             melody_hold;
  logic             sfx_active;
  logic [1:0]       sfx_id;

  modport master (
    output en, melody_inc, sfx_req,
    input  tone_inc, melody_hold, sfx_active, sfx_id
  );

  modport slave (
    input  en, melody_inc, sfx_req,
    output tone_inc, melody_hold, sfx_active, sfx_id
  );
endinterface

// File: rtl/sound_arbiter_tick_prescaler.sv
// Free-running prescaler: one-cycle tick every DIV clocks, first tick DIV
// clocks after reset release.
module tick_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap; never restarted by anything but reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/sound_arbiter.sv
// Arbitrates the tone generator between the melody sequencer and three
// two-step sound effects with fixed priority, preemption and a silent gap
// before the melody resumes.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 20
) (
  input  logic             clk,
  input  logic             rst,
  sound_arbiter_if.slave   bus,
  output sa_state_e        state_dbg,
  output logic [REQ_W-1:0] pending_dbg
);
  logic             tick;
  sa_state_e        state;
  logic [REQ_W-1:0] pending, pend_clr;
  logic [INC_W-1:0] tone_q;
  logic [DUR_W-1:0] dur_cnt, gap_cnt;
  logic [1:0]       id_q, top_id;
  logic             hold_q, active_q;
  logic             load_now, preempt, dur_done;

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Decide whether this clock loads a new effect into SFX0, and which bit to clear.
  always_comb begin
    top_id   = top_pending(pending);
    preempt  = (state == ST_SFX0 || state == ST_SFX1) && (top_id > id_q);
    dur_done = tick && (dur_cnt == DUR_W'(1));
    load_now = 1'b0;
    case (state)
      ST_MELODY: load_now = (pending != '0);
      ST_SFX0:   load_now = preempt;
      ST_SFX1:   load_now = preempt || (dur_done && pending != '0);
      ST_GAP:    load_now = (pending != '0);
      default:   load_now = 1'b0;
    endcase
    pend_clr = load_now ? id_mask(top_id) : '0;
  end

  // Arbiter FSM with pending register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_MELODY;
      pending  <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      tone_q   <= '0;
      id_q     <= SFX_NONE;
      hold_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (!bus.en) begin
      state    <= ST_MELODY;
      pending  <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      tone_q   <= '0;
      id_q     <= SFX_NONE;
      hold_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      // A new request on the same clock as its clear keeps the bit set.
      pending <= (pending & ~pend_clr) | bus.sfx_req;
      if (load_now) begin
        state    <= ST_SFX0;
        id_q     <= top_id;
        tone_q   <= sfx_inc(top_id, 1'b0);
        dur_cnt  <= sfx_dur(top_id, 1'b0);
        gap_cnt  <= '0;
        hold_q   <= 1'b1;
        active_q <= 1'b1;
      end else begin
        case (state)
          ST_MELODY: tone_q <= bus.melody_inc;
          ST_SFX0: begin
            if (dur_done) begin
              state   <= ST_SFX1;
              tone_q  <= sfx_inc(id_q, 1'b1);
              dur_cnt <= sfx_dur(id_q, 1'b1);
            end else if (tick) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end
          end
          ST_SFX1: begin
            if (dur_done) begin
              state    <= ST_GAP;
              tone_q   <= '0;
              dur_cnt  <= '0;
              gap_cnt  <= DUR_W'(GAP_TICKS);
              id_q     <= SFX_NONE;
              active_q <= 1'b0;
            end else if (tick) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end
          end
          ST_GAP: begin
            if (tick) begin
              if (gap_cnt == DUR_W'(1)) begin
                state   <= ST_MELODY;
                gap_cnt <= '0;
                hold_q  <= 1'b0;
                tone_q  <= bus.melody_inc;
              end else begin
                gap_cnt <= gap_cnt - DUR_W'(1);
              end
            end
          end
          default: state <= ST_MELODY;
        endcase
      end
    end
  end

  assign bus.tone_inc    = tone_q;
  assign bus.melody_hold = hold_q;
  assign bus.sfx_active  = active_q;
  assign bus.sfx_id      = id_q;
  assign state_dbg       = state;
  assign pending_dbg     = pending;
endmodule
